// File: rtl/pim_input_loader_if.sv
// Handshake bundle between the CPU write port / PIM array and pim_input_loader.
// The slave modport is the loader's view; the master modport is the surrounding system's view.
interface pim_input_loader_if #(
    parameter int WORDS = 32,
    parameter int DW    = 32
);
    localparam int VW = WORDS * DW;
    localparam int CW = $clog2(WORDS + 1);

    logic [2:0]    pim_mode_i;
    logic          wr_en_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_ready_o;
    logic          flush_i;
    logic [CW-1:0] fill_cnt_o;
    logic [VW-1:0] pim_input_o;
    logic          pim_valid_o;
    logic          pim_ready_i;
    logic          pim_done_i;
    logic          err_o;

    modport master (
        output pim_mode_i, wr_en_i, wr_data_i, flush_i, pim_ready_i, pim_done_i,
        input  wr_ready_o, fill_cnt_o, pim_input_o, pim_valid_o, err_o
    );

    modport slave (
        input  pim_mode_i, wr_en_i, wr_data_i, flush_i, pim_ready_i, pim_done_i,
        output wr_ready_o, fill_cnt_o, pim_input_o, pim_valid_o, err_o
    );
endinterface

// File: rtl/pim_input_loader.sv
// Double-buffered PIM input vector loader: the CPU fills one bank word by word (MSB-first)
// while the other bank is presented to the PIM array and held until it signals done.
module pim_input_loader #(
    parameter int WORDS = 32,
    parameter int DW    = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    pim_input_loader_if.slave bus
);
    localparam int VW = WORDS * DW;
    localparam int CW = $clog2(WORDS + 1);

    localparam logic [2:0] PIM_PARALLEL = 3'b101;
    localparam logic [2:0] PIM_RBR      = 3'b110;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        READY,
        BUSY
    } bank_state_t;

    bank_state_t   state [2];
    logic [VW-1:0] data  [2];
    logic          wptr;
    logic          rptr;
    logic [CW-1:0] fill_cnt;
    logic          err;

    logic wr_ready;
    logic mode_ok;
    logic wr_accept;
    logic wr_last;

    always_comb begin
        wr_ready  = (state[wptr] == EMPTY) || (state[wptr] == FILL);
        mode_ok   = (bus.pim_mode_i == PIM_PARALLEL) || (bus.pim_mode_i == PIM_RBR);
        wr_accept = bus.wr_en_i && wr_ready && mode_ok && !bus.flush_i;
        wr_last   = (fill_cnt == CW'(WORDS - 1));
    end

    // Fill side only ever touches an EMPTY/FILL bank and the present side only a READY/BUSY
    // one, so both halves below may update the same cycle without colliding even if wptr==rptr.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            data[0]  <= '0;
            data[1]  <= '0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            fill_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (bus.flush_i) begin
                if (state[wptr] == FILL) begin
                    state[wptr] <= EMPTY;
                    data[wptr]  <= '0;
                end
                fill_cnt <= '0;
                err      <= 1'b0;
            end else if (wr_accept) begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (fill_cnt == CW'(i)) begin
                        data[wptr][(WORDS-1-i)*DW +: DW] <= bus.wr_data_i;
                    end
                end
                if (wr_last) begin
                    state[wptr] <= READY;
                    fill_cnt    <= '0;
                    wptr        <= ~wptr;
                end else begin
                    state[wptr] <= FILL;
                    fill_cnt    <= fill_cnt + 1'b1;
                end
            end else if (bus.wr_en_i) begin
                err <= 1'b1;
            end

            if (state[rptr] == READY && bus.pim_ready_i) begin
                state[rptr] <= BUSY;
            end else if (state[rptr] == BUSY && bus.pim_done_i) begin
                state[rptr] <= EMPTY;
                data[rptr]  <= '0;
                rptr        <= ~rptr;
            end
        end
    end

    assign bus.wr_ready_o  = wr_ready;
    assign bus.fill_cnt_o  = fill_cnt;
    assign bus.pim_input_o = data[rptr];
    assign bus.pim_valid_o = (state[rptr] == READY);
    assign bus.err_o       = err;
endmodule

// File: tb/tb_pim_input_loader.sv
// Scoreboard bench for pim_input_loader: directed scenarios plus a randomized stream,
// checked against a queue-based model of the two-bank loader.
module tb_pim_input_loader;
    localparam int WORDS = 32;
    localparam int DW    = 32;
    localparam int VW    = WORDS * DW;

    localparam logic [2:0] M_READ = 3'b011;
    localparam logic [2:0] M_PAR  = 3'b101;
    localparam logic [2:0] M_RBR  = 3'b110;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pim_input_loader_if #(.WORDS(WORDS), .DW(DW)) bus ();

    pim_input_loader #(.WORDS(WORDS), .DW(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    logic auto_pim  = 1'b0;
    logic rnd_ready = 1'b0;
    logic rnd_done  = 1'b0;
    logic man_ready = 1'b0;
    logic man_done  = 1'b0;
    assign bus.pim_ready_i = auto_pim ? rnd_ready : man_ready;
    assign bus.pim_done_i  = auto_pim ? rnd_done  : man_done;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            for (int w = WORDS - 1; w >= 0; w--) begin
                if (act[w*DW +: DW] !== exp[w*DW +: DW]) begin
                    $display("FAIL %s: word at bit %0d got %0h expected %0h", name, w*DW,
                             act[w*DW +: DW], exp[w*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    // Reference model: complete vectors are counted, partial fill kept as a word list.
    logic [DW-1:0] m_part[$];
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] taken_vec;
    logic [VW-1:0] m_vec;
    int            m_held;
    bit            m_taken;
    bit            m_err;
    bit            m_v;
    bit            m_acc;
    bit            m_rel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_part.delete();
            exp_q.delete();
            m_held  = 0;
            m_taken = 0;
            m_err   = 0;
        end else begin
            m_v   = (m_held > 0) && !m_taken;
            m_acc = bus.wr_en_i && !bus.flush_i && m_held < 2 &&
                    (bus.pim_mode_i == M_PAR || bus.pim_mode_i == M_RBR);
            m_rel = bus.pim_done_i && m_taken;
            if (bus.flush_i) begin
                m_part.delete();
                m_err = 0;
            end else if (bus.wr_en_i && !m_acc) begin
                m_err = 1;
            end
            if (m_acc) begin
                m_part.push_back(bus.wr_data_i);
                if (m_part.size() == WORDS) begin
                    m_vec = '0;
                    foreach (m_part[i]) m_vec = (m_vec << DW) | VW'(m_part[i]);
                    exp_q.push_back(m_vec);
                    m_held++;
                    m_part.delete();
                end
            end
            if (m_v && bus.pim_ready_i) m_taken = 1;
            if (m_rel) begin
                m_held--;
                m_taken = 0;
            end
        end
    end

    // Monitor: status every cycle, presented vector against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            check("wr_ready", 32'(bus.wr_ready_o), 32'(m_held < 2));
            check("pim_valid", 32'(bus.pim_valid_o), 32'((m_held > 0) && !m_taken));
            check("fill_cnt", 32'(bus.fill_cnt_o), 32'(m_part.size()));
            check("err", 32'(bus.err_o), 32'(m_err));
            if (bus.pim_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL scoreboard: vector presented but none expected");
                end else begin
                    check_vec("pim_input", bus.pim_input_o, exp_q[0]);
                    if (bus.pim_ready_i) taken_vec = exp_q.pop_front();
                end
            end else if (m_taken) begin
                check_vec("pim_input_held", bus.pim_input_o, taken_vec);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 2) == 0);
            rnd_done  = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [DW-1:0] w);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = w;
        tick();
        bus.wr_en_i = 1'b0;
    endtask

    task automatic take_and_release();
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        man_done  = 1'b1;
        tick();
        man_done = 1'b0;
    endtask

    logic [VW-1:0] clean_vec;
    int            r;

    initial begin
        bus.pim_mode_i = M_PAR;
        bus.wr_en_i    = 1'b0;
        bus.wr_data_i  = '0;
        bus.flush_i    = 1'b0;
        repeat (2) tick();
        check("rst_wr_ready", 32'(bus.wr_ready_o), 32'd1);
        check("rst_valid", 32'(bus.pim_valid_o), 32'd0);
        check("rst_fill", 32'(bus.fill_cnt_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check_vec("rst_input", bus.pim_input_o, '0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 32; k++) write(32'(k));
        check("full_valid", 32'(bus.pim_valid_o), 32'd1);
        check("full_top", bus.pim_input_o[VW-1 -: DW], 32'd0);
        check("full_low", bus.pim_input_o[DW-1:0], 32'h1F);

        for (int k = 0; k < 32; k++) write(32'(100 + k));
        check("both_full_ready", 32'(bus.wr_ready_o), 32'd0);
        write(32'hDEAD_BEEF);
        check("overflow_err", 32'(bus.err_o), 32'd1);
        check("overflow_b0_low", bus.pim_input_o[DW-1:0], 32'h1F);
        check("overflow_b0_top", bus.pim_input_o[VW-1 -: DW], 32'd0);

        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        check("taken_valid", 32'(bus.pim_valid_o), 32'd0);
        check("taken_hold", bus.pim_input_o[DW-1:0], 32'h1F);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check("release_valid", 32'(bus.pim_valid_o), 32'd1);
        check("release_b1_low", bus.pim_input_o[DW-1:0], 32'd131);
        check("release_b1_top", bus.pim_input_o[VW-1 -: DW], 32'd100);
        check("release_wr_ready", 32'(bus.wr_ready_o), 32'd1);

        for (int i = 0; i < 10; i++) write(32'hAAAA_0000 + 32'(i));
        check("partial_fill", 32'(bus.fill_cnt_o), 32'd10);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush_fill", 32'(bus.fill_cnt_o), 32'd0);
        check("flush_err", 32'(bus.err_o), 32'd0);
        clean_vec = '0;
        for (int i = 0; i < 32; i++) begin
            write(32'h5000 + 32'(i));
            clean_vec = (clean_vec << DW) | VW'(32'h5000 + 32'(i));
        end
        take_and_release();
        check("clean_valid", 32'(bus.pim_valid_o), 32'd1);
        check_vec("clean_vec", bus.pim_input_o, clean_vec);
        take_and_release();
        check("drained_valid", 32'(bus.pim_valid_o), 32'd0);

        bus.pim_mode_i = M_READ;
        write(32'd7);
        check("bad_mode_fill", 32'(bus.fill_cnt_o), 32'd0);
        check("bad_mode_err", 32'(bus.err_o), 32'd1);
        bus.pim_mode_i = M_PAR;
        bus.flush_i    = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("err_cleared", 32'(bus.err_o), 32'd0);

        auto_pim = 1'b1;
        repeat (3000) begin
            r = $urandom_range(0, 19);
            bus.pim_mode_i = (r == 0) ? M_READ : (r[0] ? M_PAR : M_RBR);
            bus.flush_i    = ($urandom_range(0, 49) == 0);
            bus.wr_en_i    = ($urandom_range(0, 2) != 0);
            bus.wr_data_i  = $urandom;
            tick();
        end
        bus.wr_en_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.pim_mode_i = M_PAR;
        auto_pim       = 1'b0;
        tick();
        repeat (3) take_and_release();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;

        for (int i = 0; i < 5; i++) write(32'h7700 + 32'(i));
        check("pre_reset_fill", 32'(bus.fill_cnt_o), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_fill", 32'(bus.fill_cnt_o), 32'd0);
        check("async_rst_valid", 32'(bus.pim_valid_o), 32'd0);
        check("async_rst_wr_ready", 32'(bus.wr_ready_o), 32'd1);
        check("async_rst_err", 32'(bus.err_o), 32'd0);
        check_vec("async_rst_input", bus.pim_input_o, '0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_fill", 32'(bus.fill_cnt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/pim_input_loader.md
PIM_INPUT_LOADER -- requirements
Module: pim_input_loader

Interface
REQ-001 SHALL have parameter WORDS, default 32: number of 32-bit words per PIM input vector.
REQ-002 SHALL have parameter DW, default 32: word width in bits; vector width VW = WORDS*DW (1024 at defaults).
REQ-003 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port pim_mode_i, input, 3: PIM mode; PIM_READ=3'b011, PIM_PARALLEL=3'b101, PIM_RBR=3'b110.
REQ-006 SHALL have port wr_en_i, input, 1: CPU-side word write strobe.
REQ-007 SHALL have port wr_data_i, input, DW: write word.
REQ-008 SHALL have port wr_ready_o, output, 1: fill bank can accept a word.
REQ-009 SHALL have port flush_i, input, 1: discard partial fill, clear error.
REQ-010 SHALL have port fill_cnt_o, output, $clog2(WORDS+1): words held in fill bank.
REQ-011 SHALL have port pim_input_o, output, VW: vector presented to PIM array.
REQ-012 SHALL have port pim_valid_o, output, 1: presented bank complete, not yet taken.
REQ-013 SHALL have port pim_ready_i, input, 1: PIM accepts presented vector.
REQ-014 SHALL have port pim_done_i, input, 1: PIM finished with taken vector; releases bank.
REQ-015 SHALL have port err_o, output, 1: sticky rejected-write flag.

Function
REQ-016 SHALL hold two banks B0/B1, each with state EMPTY, FILL, READY or BUSY, a fill pointer wptr and a present pointer rptr.
REQ-017 SHALL accept a write when wr_en_i=1, wr_ready_o=1, flush_i=0 and pim_mode_i is PIM_PARALLEL or PIM_RBR.
REQ-018 SHALL drive wr_ready_o=1 iff bank[wptr] is EMPTY or FILL.
REQ-019 SHALL store the k-th accepted word (k=0 first) at bits [VW-1-DW*k -: DW] of bank[wptr], MSB-first, k counted by fill_cnt_o.
REQ-020 SHALL move bank[wptr] EMPTY->FILL on its first accepted word.
REQ-021 SHALL, on the accepted word with fill_cnt_o=WORDS-1, set bank[wptr] to READY, reset fill_cnt_o to 0 and toggle wptr, all at the same edge.
REQ-022 SHALL drive pim_valid_o=1 iff bank[rptr] is READY; a final word written at edge n into bank[rptr] gives pim_valid_o=1 after edge n.
REQ-023 SHALL drive pim_input_o from bank[rptr] contents at all times, stable while bank[rptr] is READY or BUSY.
REQ-024 SHALL, on pim_valid_o=1 and pim_ready_i=1, move bank[rptr] READY->BUSY; pim_valid_o=0 after that edge.
REQ-025 SHALL, on pim_done_i=1 with bank[rptr] BUSY, move it to EMPTY, zero its data and toggle rptr.
REQ-026 SHALL ignore pim_ready_i when pim_valid_o=0 and pim_done_i when bank[rptr] is not BUSY.
REQ-027 SHALL apply a release (REQ-025) and a write or completion (REQ-021) in the same cycle independently, as both touch different banks.
REQ-028 SHALL, on flush_i=1, return a FILL bank[wptr] to EMPTY with zeroed data and fill_cnt_o=0, leave READY/BUSY banks untouched and clear err_o.
REQ-029 SHALL give flush_i priority over a same-cycle write: the write is dropped and err_o is not set.
REQ-030 SHALL set err_o when wr_en_i=1, flush_i=0 and the write is not accepted (not ready or invalid mode); err_o holds until flush_i or reset; dropped writes change no other state.

Reset
REQ-031 SHALL, while rst_ni=0, asynchronously force both banks EMPTY with zero data, wptr=rptr=0, fill_cnt_o=0, pim_input_o=0, pim_valid_o=0, err_o=0, wr_ready_o=1.
REQ-032 SHALL discard any partial fill or in-flight handshake on reset, including a reset asserted mid-fill.

Verification
REQ-033 SHALL cover: PARALLEL mode, 32 writes of data k -> pim_valid_o=1 one cycle after 32nd; pim_input_o[1023:992]=0, [31:0]=0x0000001F.
REQ-034 SHALL cover: fill 64 words with no pim_ready_i -> wr_ready_o=0 after 64th; 65th write -> err_o=1, B0 contents unchanged.
REQ-035 SHALL cover: pim_ready_i on B0 -> pim_valid_o=0 with data held; pim_done_i -> pim_valid_o=1 next cycle showing B1 data, wr_ready_o=1.
REQ-036 SHALL cover: 10 words then flush_i -> fill_cnt_o=0, err_o=0; next 32 words give a clean vector with no remnants.
REQ-037 SHALL cover: pim_mode_i=3'b011 with wr_en_i=1 -> no write, fill_cnt_o=0, err_o=1.
REQ-038 SHALL cover: rst_ni low after 5 words, between clock edges -> all outputs reset immediately, fill_cnt_o=0.
